// File: rtl/bram16_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bram16_ctrl_pkg
// Shared definitions for the 16-bit block RAM controller:
//   - state_t   : controller FSM state encoding (IDLE, RD, RDW, WR, ACK)
//   - LANE_HI/LANE_LO : byte-lane indices (lane 1 = data[15:8], lane 0 = data[7:0])
//   - lane_sel  : helper that picks one byte lane from either of two words
// -----------------------------------------------------------------------------
package bram16_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,   // waiting for cpu_req
        RD   = 3'd1,   // RAM address presented, read in flight
        RDW  = 3'd2,   // RAM read data valid on bram_di
        WR   = 3'd3,   // RAM write strobe
        ACK  = 3'd4    // one-cycle completion towards the CPU
    } state_t;

    localparam int LANE_HI   = 1;
    localparam int LANE_LO   = 0;
    localparam int LANE_BITS = 8;
    localparam int NUM_LANES = 2;

    // Returns byte lane 'lane' of new_word when 'use_new' is set, otherwise
    // the same lane of old_word.
    function automatic logic [LANE_BITS-1:0] lane_sel(
        input logic        use_new,
        input logic [15:0] new_word,
        input logic [15:0] old_word,
        input int          lane
    );
        logic [LANE_BITS-1:0] result;
        result = use_new ? new_word[lane*LANE_BITS +: LANE_BITS]
                         : old_word[lane*LANE_BITS +: LANE_BITS];
        return result;
    endfunction

endpackage

// File: rtl/bram16_ctrl.sv
// -----------------------------------------------------------------------------
// bram16_ctrl
// Single-request CPU-to-block-RAM bridge for a 16-bit synchronous RAM with a
// one-cycle read latency. One transaction at a time: the request is latched
// in IDLE, serviced by the FSM, and completed by a one-cycle cpu_ack.
//
// Optional feature (compile-time macro BRAM16_CTRL_BYTE_EN):
//   defined   : partial writes (cpu_be = 01 / 10) become read-modify-write
//               (RD -> RDW -> WR -> ACK), merging the unselected lane from RAM.
//   undefined : any nonzero cpu_be on a write is a full-word write.
//
// Parameters
//   adr_width  : byte-address width of the attached RAM (default 11 = 2 KiB)
//
// Ports
//   sys_clk    in   1   clock, rising edge
//   sys_rst    in   1   synchronous active-high reset
//   cpu_req    in   1   request, held until cpu_ack
//   cpu_we     in   1   1 = write, 0 = read
//   cpu_be     in   2   byte enables (bit1 = [15:8], bit0 = [7:0])
//   cpu_adr    in  16   byte address
//   cpu_dat_w  in  16   write data
//   cpu_dat_r  out 16   read data (held until the next read or error ack)
//   cpu_ack    out  1   one-cycle completion pulse
//   cpu_err    out  1   out-of-range address, qualified by cpu_ack
//   bram_a     out 16   RAM byte address (bit0 always 0)
//   bram_do    out 16   RAM write data
//   bram_we    out  1   RAM write enable
//   bram_di    in  16   RAM read data, one cycle after bram_a
// -----------------------------------------------------------------------------
module bram16_ctrl
    import bram16_ctrl_pkg::*;
#(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_adr,
    input  logic [15:0] cpu_dat_w,
    output logic [15:0] cpu_dat_r,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [15:0] bram_a,
    output logic [15:0] bram_do,
    output logic        bram_we,
    input  logic [15:0] bram_di
);

    // Address bits at or above adr_width must be zero; the mask is computed
    // in 32 bits so adr_width = 16 yields an all-zero mask (no range check).
    localparam logic [31:0] LOW_MASK = (32'd1 << adr_width) - 32'd1;
    localparam logic [15:0] HI_MASK  = ~LOW_MASK[15:0];

    state_t      state_reg;
    state_t      state_next;

    // Request latches, loaded only when a request is accepted in IDLE so
    // that cpu_* activity during a transaction has no effect.
    logic        we_reg;
    logic [15:0] adr_reg;
    logic [15:0] dat_reg;

    logic        cpu_ack_reg;
    logic        cpu_err_reg;
    logic [15:0] cpu_dat_r_reg;

    logic        accept;
    logic        adr_oor;

    assign accept  = (state_reg == IDLE) && cpu_req;
    assign adr_oor = |(cpu_adr & HI_MASK);

`ifdef BRAM16_CTRL_BYTE_EN
    logic [1:0]  be_reg;
    logic [15:0] merge_data;
    logic        partial_be;

    assign partial_be = (cpu_be == 2'b01) || (cpu_be == 2'b10);

    // Read-modify-write merge: enabled lanes keep the latched CPU data,
    // disabled lanes take the word just read from RAM (valid in RDW).
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_merge
            assign merge_data[gi*LANE_BITS +: LANE_BITS] =
                lane_sel(be_reg[gi], dat_reg, bram_di, gi);
        end
    endgenerate
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (adr_oor) begin
                        state_next = ACK;
                    end else if (!cpu_we) begin
                        state_next = RD;
                    end else if (cpu_be == 2'b00) begin
                        // Nothing to write: complete immediately.
                        state_next = ACK;
`ifdef BRAM16_CTRL_BYTE_EN
                    end else if (partial_be) begin
                        state_next = RD;
`endif
                    end else begin
                        state_next = WR;
                    end
                end
            end
            RD:      state_next = RDW;
            // A write only reaches RDW on the read-modify-write path.
            RDW:     state_next = we_reg ? WR : ACK;
            WR:      state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, latches and registered CPU-side outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            adr_reg       <= 16'h0000;
            dat_reg       <= 16'h0000;
            cpu_ack_reg   <= 1'b0;
            cpu_err_reg   <= 1'b0;
            cpu_dat_r_reg <= 16'h0000;
`ifdef BRAM16_CTRL_BYTE_EN
            be_reg        <= 2'b00;
`endif
        end else begin
            state_reg   <= state_next;
            // High exactly while the state register holds ACK.
            cpu_ack_reg <= (state_next == ACK);

            if (accept) begin
                we_reg  <= cpu_we;
                adr_reg <= cpu_adr;
                dat_reg <= cpu_dat_w;
`ifdef BRAM16_CTRL_BYTE_EN
                be_reg  <= cpu_be;
`endif
            end

            // Error status is set up alongside the entry into ACK; only the
            // out-of-range path goes straight from IDLE with an error.
            if (accept && adr_oor) begin
                cpu_err_reg   <= 1'b1;
                cpu_dat_r_reg <= 16'h0000;
            end else if (state_next == ACK) begin
                cpu_err_reg   <= 1'b0;
            end

            if (state_reg == RDW) begin
                if (!we_reg) begin
                    cpu_dat_r_reg <= bram_di;
`ifdef BRAM16_CTRL_BYTE_EN
                end else begin
                    dat_reg <= merge_data;
`endif
                end
            end
        end
    end

    assign cpu_ack   = cpu_ack_reg;
    assign cpu_err   = cpu_err_reg;
    assign cpu_dat_r = cpu_dat_r_reg;

    // RAM side decodes straight from state and latches; the RAM is 16 bits
    // wide so the byte address is always word-aligned.
    assign bram_a  = adr_reg & 16'hFFFE;
    assign bram_do = dat_reg;
    assign bram_we = (state_reg == WR);

endmodule

// File: tb/tb_bram16_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram16_ctrl
// Scoreboard bench for bram16_ctrl with a behavioural 1024 x 16 block RAM.
// Each transaction pushes its expected ack cycle, error flag and read data;
// a negedge monitor pops and compares on every cpu_ack.
// -----------------------------------------------------------------------------
module tb_bram16_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we  = 1'b0;
    logic [1:0]  cpu_be  = 2'b00;
    logic [15:0] cpu_adr = 16'h0000;
    logic [15:0] cpu_dat_w = 16'h0000;
    logic [15:0] cpu_dat_r;
    logic        cpu_ack;
    logic        cpu_err;
    logic [15:0] bram_a;
    logic [15:0] bram_do;
    logic        bram_we;
    logic [15:0] bram_di;

    bram16_ctrl #(.adr_width(11)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_adr   (cpu_adr),
        .cpu_dat_w (cpu_dat_w),
        .cpu_dat_r (cpu_dat_r),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .bram_a    (bram_a),
        .bram_do   (bram_do),
        .bram_we   (bram_we),
        .bram_di   (bram_di)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural RAM: registered read, read-before-write.
    logic [15:0] ram [0:1023];
    always @(posedge sys_clk) begin
        if (bram_we) ram[bram_a[10:1]] <= bram_do;
        bram_di <= ram[bram_a[10:1]];
    end

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int we_cnt = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (bram_we === 1'b1) we_cnt <= we_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] dat;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    logic [15:0] shadow [0:1023];
    logic [15:0] exp_dat_r = 16'h0000;

    // Scoreboard monitor
    always @(negedge sys_clk) begin
        exp_t  e;
        string t;
        if (!sys_rst && cpu_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                check_eq({t, "_ack_cycle"}, cyc, e.cyc);
                check_eq({t, "_err"}, {31'd0, cpu_err}, {31'd0, e.err});
                check_eq({t, "_dat_r"}, {16'd0, cpu_dat_r}, {16'd0, e.dat});
                $display("ack %-14s cycle %0d err %0b dat_r 0x%04h", t, cyc, cpu_err, cpu_dat_r);
            end
        end
    end

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if (cpu_ack === 1'b1) return;
        end
        check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Computes expected latency / error / data and updates the shadow memory.
    task automatic predict(input logic we, input logic [1:0] be, input logic [15:0] adr,
                           input logic [15:0] dat, output int lat, output logic err);
        logic [9:0] w;
        w   = adr[10:1];
        err = 1'b0;
        if (adr >= 16'h0800) begin
            lat = 1; err = 1'b1; exp_dat_r = 16'h0000;
        end else if (!we) begin
            lat = 3; exp_dat_r = shadow[w];
        end else if (be == 2'b00) begin
            lat = 1;
        end else if (be == 2'b11) begin
            lat = 2; shadow[w] = dat;
        end else begin
`ifdef BRAM16_CTRL_BYTE_EN
            lat = 4;
            if (be[1]) shadow[w][15:8] = dat[15:8];
            if (be[0]) shadow[w][7:0]  = dat[7:0];
`else
            lat = 2; shadow[w] = dat;
`endif
        end
    endtask

    task automatic push_exp(input string tag, input int c, input logic err);
        exp_t e;
        e.cyc = c; e.err = err; e.dat = exp_dat_r;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [1:0] be,
                           input logic [15:0] adr, input logic [15:0] dat);
        int   lat;
        logic err;
        @(posedge sys_clk); #1;
        predict(we, be, adr, dat, lat, err);
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_adr = adr; cpu_dat_w = dat;
        push_exp(tag, cyc + lat, err);
        wait_ack(tag);
        cpu_req = 1'b0;
        // Scramble the idle bus so stale inputs cannot mask a latch fault.
        cpu_dat_w = 16'h5A5A; cpu_be = ~be; cpu_we = ~we;
    endtask

    initial begin : main
        int   ack_cyc, lat, w0;
        logic err;
        for (int i = 0; i < 1024; i++) begin ram[i] = 16'h0000; shadow[i] = 16'h0000; end

        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check_eq("rst_ack",    {31'd0, cpu_ack}, 32'd0);
        check_eq("rst_err",    {31'd0, cpu_err}, 32'd0);
        check_eq("rst_dat_r",  {16'd0, cpu_dat_r}, 32'd0);
        check_eq("rst_bram_we",{31'd0, bram_we}, 32'd0);
        check_eq("rst_bram_a", {16'd0, bram_a}, 32'd0);

        run_txn("wr_beef",   1'b1, 2'b11, 16'h0010, 16'hBEEF);
        run_txn("rd_beef",   1'b0, 2'b00, 16'h0010, 16'h0000);
        run_txn("rd_odd",    1'b0, 2'b01, 16'h0011, 16'h0000);
        run_txn("wr_1234",   1'b1, 2'b11, 16'h0020, 16'h1234);
        run_txn("wr_be10",   1'b1, 2'b10, 16'h0020, 16'hAB00);
        run_txn("rd_be10",   1'b0, 2'b11, 16'h0020, 16'h0000);
        run_txn("wr_be01",   1'b1, 2'b01, 16'h0020, 16'h00CD);
        run_txn("rd_be01",   1'b0, 2'b00, 16'h0020, 16'h0000);
        run_txn("wr_be00",   1'b1, 2'b00, 16'h0020, 16'hFFFF);
        run_txn("rd_be00",   1'b0, 2'b00, 16'h0020, 16'h0000);

        w0 = we_cnt;
        run_txn("rd_oor",    1'b0, 2'b11, 16'h0800, 16'h0000);
        run_txn("wr_oor",    1'b1, 2'b11, 16'hF000, 16'h7777);
        check_eq("oor_no_we", we_cnt - w0, 32'd0);
        run_txn("rd_after_oor", 1'b0, 2'b00, 16'h0000, 16'h0000);

        // Back-to-back reads with cpu_req held through ACK
        run_txn("wr_2222", 1'b1, 2'b11, 16'h0002, 16'h2222);
        run_txn("wr_4444", 1'b1, 2'b11, 16'h0004, 16'h4444);
        @(posedge sys_clk); #1;
        predict(1'b0, 2'b00, 16'h0002, 16'h0000, lat, err);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b00; cpu_adr = 16'h0002;
        push_exp("b2b_rd0", cyc + lat, err);
        wait_ack("b2b_rd0");
        ack_cyc = cyc;
        cpu_adr = 16'h0004;
        predict(1'b0, 2'b00, 16'h0004, 16'h0000, lat, err);
        push_exp("b2b_rd1", cyc + 1 + lat, err);
        wait_ack("b2b_rd1");
        cpu_req = 1'b0;
        check_eq("b2b_spacing", cyc - ack_cyc, 32'd4);

        // Reset sampled on the accept edge: the write never starts.
        run_txn("wr_1111", 1'b1, 2'b11, 16'h0030, 16'h1111);
        @(posedge sys_clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_adr = 16'h0030; cpu_dat_w = 16'h5555;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        cpu_req = 1'b0; sys_rst = 1'b0; exp_dat_r = 16'h0000;
        @(negedge sys_clk);
        check_eq("rstA_bram_we", {31'd0, bram_we}, 32'd0);
        check_eq("rstA_dat_r",   {16'd0, cpu_dat_r}, 32'd0);
        repeat (3) @(negedge sys_clk);
        run_txn("rd_rstA", 1'b0, 2'b00, 16'h0030, 16'h0000);

        // Reset during WR: the write strobe of that cycle lands, no ack follows.
        @(posedge sys_clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_adr = 16'h0030; cpu_dat_w = 16'h5555;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_eq("rstB_we_in_wr", {31'd0, bram_we}, 32'd1);
        sys_rst = 1'b1; cpu_req = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0; exp_dat_r = 16'h0000; shadow[16'h0030 >> 1] = 16'h5555;
        @(negedge sys_clk);
        check_eq("rstB_bram_we", {31'd0, bram_we}, 32'd0);
        check_eq("rstB_bram_a",  {16'd0, bram_a}, 32'd0);
        check_eq("rstB_no_ack",  {31'd0, cpu_ack}, 32'd0);
        repeat (4) @(negedge sys_clk);
        run_txn("rd_rstB", 1'b0, 2'b00, 16'h0030, 16'h0000);

        repeat (4) @(negedge sys_clk);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
